// File: rtl/rate_buffer.sv
// rate_buffer: single-clock word buffer that absorbs a full-rate producer
// stream and re-emits words at one slot every OUT_DIV cycles.
//
// Ports:
//   clk           system clock, all logic on rising edge
//   rst           synchronous active-high reset
//   mode          0 = streaming, 1 = burst (fill until full, drain until empty)
//   data_1_en     write strobe, accepted when buffer_full=0
//   data_1        write data
//   buffer_empty  occupancy == 0 (registered)
//   buffer_full   occupancy == DEPTH (registered)
//   data_2_valid  one-cycle pulse when data_2 holds a newly popped word
//   data_2        registered read data, held between pops
//   overflow      sticky refused-write flag
//
// Optional feature: define RATE_BUFFER_OVF_EN to build the sticky overflow
// flag; otherwise overflow is tied to 0 and refused writes are silently dropped.

module rate_buffer #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8,
    parameter int OUT_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              data_1_en,
    input  logic [DATA_W-1:0] data_1,
    output logic              buffer_empty,
    output logic              buffer_full,
    output logic              data_2_valid,
    output logic [DATA_W-1:0] data_2,
    output logic              overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [CW-1:0] slot;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          tick;
    logic          wr_en;
    logic          read_ok;

    // Slot counter: free-running, wraps every OUT_DIV cycles.
    generate
        if (OUT_DIV == 1) begin : g_tick_always
            assign tick = 1'b1;
        end else begin : g_tick_div
            assign tick = (slot == CW'(OUT_DIV - 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (tick) begin
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    assign wr_en = data_1_en && !buffer_full;

    // FILL never pops; STREAM and DRAIN pop on every tick with data.
    assign read_ok = tick && !buffer_empty && (state != FILL);

    always_comb begin
        count_nxt = count;
        case ({wr_en, read_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Mode is only honoured when the buffer is idle-empty, so a switch
    // never reorders or strands words already stored.
    always_comb begin
        state_nxt = state;
        if (buffer_empty && !wr_en) begin
            state_nxt = mode ? FILL : STREAM;
        end else begin
            case (state)
                FILL: begin
                    if (count_nxt == FULL_CNT) state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (count_nxt == '0) state_nxt = FILL;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Storage is not reset; occupancy tracking makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            state        <= FILL;
            buffer_empty <= 1'b1;
            buffer_full  <= 1'b0;
            data_2_valid <= 1'b0;
            data_2       <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                data_2 <= mem[rd_ptr];
            end
            count        <= count_nxt;
            state        <= state_nxt;
            buffer_empty <= (count_nxt == '0);
            buffer_full  <= (count_nxt == FULL_CNT);
            data_2_valid <= read_ok;
        end
    end

`ifdef RATE_BUFFER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (data_1_en && buffer_full) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_rate_buffer.sv
// tb_rate_buffer: directed plus randomized stimulus for rate_buffer,
// checked cycle by cycle against a queue-based behavioural model.

module tb_rate_buffer;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 8;
    localparam int OUT_DIV = 2;

    localparam int P_FILL   = 0;
    localparam int P_DRAIN  = 1;
    localparam int P_STREAM = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mode = 1'b0;
    logic              data_1_en = 1'b0;
    logic [DATA_W-1:0] data_1 = '0;
    logic              buffer_empty;
    logic              buffer_full;
    logic              data_2_valid;
    logic [DATA_W-1:0] data_2;
    logic              overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] q [$];
    int                ph = P_FILL;
    int                cyc = 0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_valid = 1'b0;
    logic              m_ovf = 1'b0;
    int                pops_seen = 0;

    rate_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .OUT_DIV(OUT_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .data_1_en   (data_1_en),
        .data_1      (data_1),
        .buffer_empty(buffer_empty),
        .buffer_full (buffer_full),
        .data_2_valid(data_2_valid),
        .data_2      (data_2),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model advances on the same inputs the DUT samples.
    task automatic step();
        logic              s_rst;
        logic              s_en;
        logic              s_mode;
        logic [DATA_W-1:0] s_d;
        logic              full_b;
        logic              empty_b;
        logic              tick_b;
        logic              wr;
        logic              pop;
        logic              exp_ovf;
        s_rst  = rst;
        s_en   = data_1_en;
        s_mode = mode;
        s_d    = data_1;
        @(posedge clk);
        #1;
        if (s_rst) begin
            q.delete();
            ph      = P_FILL;
            cyc     = 0;
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            full_b  = (q.size() == DEPTH);
            empty_b = (q.size() == 0);
            tick_b  = ((cyc % OUT_DIV) == OUT_DIV - 1);
            wr      = s_en && !full_b;
            pop     = tick_b && !empty_b && (ph != P_FILL);
            m_valid = pop;
            if (pop) begin
                m_data = q.pop_front();
                pops_seen++;
            end
            if (wr) q.push_back(s_d);
            if (s_en && full_b) m_ovf = 1'b1;
            if (empty_b && !wr) ph = s_mode ? P_FILL : P_STREAM;
            else if (ph == P_FILL && q.size() == DEPTH) ph = P_DRAIN;
            else if (ph == P_DRAIN && q.size() == 0) ph = P_FILL;
            cyc = (cyc + 1) % OUT_DIV;
        end
`ifdef RATE_BUFFER_OVF_EN
        exp_ovf = m_ovf;
`else
        exp_ovf = 1'b0;
`endif
        chk("buffer_empty", 32'(buffer_empty), 32'(q.size() == 0));
        chk("buffer_full", 32'(buffer_full), 32'(q.size() == DEPTH));
        chk("data_2_valid", 32'(data_2_valid), 32'(m_valid));
        chk("data_2", 32'(data_2), 32'(m_data));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic idle(input int n);
        data_1_en = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_seq(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            data_1_en = 1'b1;
            data_1    = DATA_W'(first + i);
            step();
        end
        data_1_en = 1'b0;
    endtask

    initial begin
        // Reset held with the write strobe active.
        rst       = 1'b1;
        data_1_en = 1'b1;
        data_1    = 16'hBEEF;
        step();
        step();
        rst       = 1'b0;
        data_1_en = 1'b0;
        mode      = 1'b0;
        idle(2);

        // Streaming: eight back-to-back writes.
        write_seq(1, 8);
        idle(12);

        // Burst: select while empty, fill, then drain.
        mode = 1'b1;
        idle(1);
        write_seq(1, 8);
        idle(20);

        // Burst with two writes past full.
        write_seq(1, 10);
        idle(24);

        // Mode switch while non-empty is deferred until empty.
        mode = 1'b0;
        idle(2);
        write_seq(100, 3);
        mode = 1'b1;
        idle(10);
        write_seq(200, 8);
        idle(20);

        // Long streaming run wraps the pointers several times.
        mode = 1'b0;
        idle(2);
        write_seq(1, 20);
        idle(40);

        // Randomized traffic with occasional mode flips and resets.
        for (int i = 0; i < 1500; i++) begin
            data_1_en = ($urandom_range(0, 99) < 55);
            data_1    = DATA_W'($urandom);
            if ($urandom_range(0, 99) < 3) mode = ~mode;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        idle(40);

        // Mid-operation reset discards stored words.
        write_seq(300, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(6);

        chk("pops_seen_nonzero", 32'(pops_seen > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rate_buffer.md
Name: rate_buffer

Overview:
- Single-clock, parametrised successor to the T3 16-bit dual-clock buffer.
- Absorbs a word stream arriving at full clock rate on the producer side (data_1).
- Emits buffered words at a programmable reduced rate (one slot every OUT_DIV cycles) on the consumer side (data_2).
- Adds a runtime-selectable streaming or burst (fill-then-drain) mode.
- Sits between a fast producer and a slow/paced consumer inside one clock domain.

Parameters:
DATA_W, 16, word width of data_1/data_2
DEPTH, 8, buffer entries; power of two, >= 2
OUT_DIV, 2, output slot period in clk cycles; >= 1 (1 = every cycle)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
mode  in  1  0 = streaming, 1 = burst (fill until full, then drain until empty)
data_1_en  in  1  write strobe; data_1 is accepted when data_1_en=1 and buffer_full=0
data_1  in  DATA_W  write data
buffer_empty  out  1  occupancy == 0
buffer_full  out  1  occupancy == DEPTH
data_2_valid  out  1  one-cycle pulse; data_2 holds a newly popped word
data_2  out  DATA_W  read data, registered, holds its value between pops
overflow  out  1  sticky; a write was refused because buffer_full=1 (see Optional Feature)

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values, applied at the first rising edge with rst=1:
  - Pointers=0, count=0, slot counter=0, FSM=FILL.
  - buffer_empty=1, buffer_full=0, data_2_valid=0, data_2=0, overflow=0.
- Reset mid-operation discards all stored words. Storage RAM contents need not be cleared.
- Storage and occupancy:
  - Circular RAM of DEPTH entries.
  - wr_ptr/rd_ptr are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is clog2(DEPTH)+1 bits. Flags are registered and derived from the next count, so they are exact in the cycle after the edge.
- Write:
  - Occurs when data_1_en=1 and buffer_full=0 at the edge.
  - A write while full is refused. The entry is not overwritten and the pointer does not move.
- Slot counter:
  - Counts 0..OUT_DIV-1 and wraps; it always runs.
  - tick=1 when counter==OUT_DIV-1, or always 1 when OUT_DIV=1.
- Read enable:
  - Streaming (state STREAM): read_ok = tick and !buffer_empty.
  - Burst: read_ok = tick and state==DRAIN and !buffer_empty.
- Pop: on read_ok, data_2 <= mem[rd_ptr], rd_ptr++, count--, data_2_valid=1 for exactly that next cycle.
- Latency: a word written into an empty buffer in streaming mode appears on data_2 at the first tick edge at least 1 cycle after the write edge. Minimum write-to-valid latency is 1 cycle at OUT_DIV=1.
- Simultaneous read and write:
  - When not full, both occur and count is unchanged.
  - When full, the write is refused even if a pop occurs in the same cycle.
  - Empty with simultaneous write: no pop in that cycle (no bypass).
- FSM states: FILL, DRAIN, STREAM.
  - FILL -> DRAIN when count reaches DEPTH.
  - DRAIN -> FILL when the last word is popped (count becomes 0).
  - STREAM is used while mode=0.
- Mode changes are sampled only when buffer_empty=1 and no write occurs in that cycle:
  - mode=0 selects STREAM.
  - mode=1 selects FILL.
  - A change while non-empty is deferred until empty.
- Words leave in exactly the order they were written; no word is lost or duplicated except refused writes.

Optional Feature:
Macro RATE_BUFFER_OVF_EN.
- Defined:
  - overflow is set on any refused write (data_1_en=1 while buffer_full=1).
  - overflow stays set until rst; it is not cleared by draining.
- Not defined:
  - overflow is tied to constant 0 and no overflow logic is synthesised.
  - Refused writes are still silently dropped.

Test Plan:
- Reset: rst=1 for 2 cycles with data_1_en=1 -> buffer_empty=1, buffer_full=0, data_2_valid=0, data_2=0 throughout; no write accepted.
- Streaming, DEPTH=8, OUT_DIV=2: write 1..8 on 8 consecutive cycles -> data_2 = 1,2,...,8 in order, data_2_valid pulses every 2nd cycle, buffer_full never asserted.
- Burst, mode=1, DEPTH=8, OUT_DIV=2: write 1..8 -> no data_2_valid until buffer_full=1; then 8 pops 1..8 at 2-cycle spacing; buffer_empty=1 after the 8th; no pop while refilling.
- Overflow (macro defined), OUT_DIV=4, mode=1: write 1..10 consecutively -> words 9 and 10 refused; overflow=1 from the cycle after word 9 onward; drained output is exactly 1..8.
- Wrap-around, streaming, OUT_DIV=1: 20 consecutive writes 1..20 -> output 1..20 in order; pointers wrap without loss or duplication.
- Mode switch while non-empty: load 3 words in streaming mode, set mode=1 -> remaining words drain in streaming manner; burst behaviour starts only after buffer_empty=1.
